// File: rtl/stream_demux4_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux4_pkg
// Shared constants and types for the packet-aware 1-to-4 stream demultiplexer.
//   NUM_CH  : number of output channels
//   SEL_W   : width of the channel selector
//   DATA_W  : payload width carried by beat_t (keep equal to the top's WIDTH)
//   state_t : packet-tracking FSM states
//   beat_t  : one stream beat (payload + end-of-packet flag)
// -----------------------------------------------------------------------------
package stream_demux4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/stream_demux4_if.sv
// -----------------------------------------------------------------------------
// stream_demux4_if
// Bundles the handshake and data signals of stream_demux4.
//   io_selector  : destination channel, sampled on the first beat of a packet
//   io_in_*      : upstream valid/ready stream (data, last)
//   io_out_*     : per-channel downstream streams, index N = channel
//   io_count     : per-channel completed-packet counters
// Modports:
//   master : the upstream producer / downstream consumer side
//   slave  : the demultiplexer itself
// -----------------------------------------------------------------------------
interface stream_demux4_if #(
  parameter int WIDTH = stream_demux4_pkg::DATA_W,
  parameter int CNT_W = 8
);
  import stream_demux4_pkg::*;

  logic [SEL_W-1:0]                   io_selector;
  logic                               io_in_valid;
  logic                               io_in_ready;
  logic [WIDTH-1:0]                   io_in_data;
  logic                               io_in_last;
  logic [NUM_CH-1:0]                  io_out_valid;
  logic [NUM_CH-1:0]                  io_out_ready;
  logic [NUM_CH-1:0][WIDTH-1:0]       io_out_data;
  logic [NUM_CH-1:0]                  io_out_last;
  logic [NUM_CH-1:0][CNT_W-1:0]       io_count;

  modport master (
    output io_selector, io_in_valid, io_in_data, io_in_last, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_data, io_out_last, io_count
  );

  modport slave (
    input  io_selector, io_in_valid, io_in_data, io_in_last, io_out_ready,
    output io_in_ready, io_out_valid, io_out_data, io_out_last, io_count
  );

endinterface

// File: rtl/stream_demux4_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry registered holding stage for a single output channel, plus the
// channel's completed-packet counter.
//   clock, reset : clock and synchronous active-high reset
//   load         : write load_beat into the slot this cycle (only when free)
//   load_beat    : beat to store
//   out_ready    : downstream consumer ready
//   out_valid    : slot holds a beat
//   out_beat     : held beat, stable while out_valid && !out_ready
//   free         : slot can take a beat this cycle (empty or draining)
//   count        : packets whose last beat has been handed downstream
// -----------------------------------------------------------------------------
module demux_slot
  import stream_demux4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  beat_t            load_beat,
  input  logic             out_ready,
  output logic             out_valid,
  output beat_t            out_beat,
  output logic             free,
  output logic [CNT_W-1:0] count
);

  logic drain;

  // A draining slot counts as free so a beat can pass straight through.
  assign free  = !out_valid || out_ready;
  assign drain = out_valid && out_ready;

  // Load wins over drain, which covers a same-cycle drain and refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
      count     <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_beat  <= load_beat;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain && out_beat.last) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stream_demux4.sv
// -----------------------------------------------------------------------------
// stream_demux4
// Packet-aware 1-to-4 stream demultiplexer. The channel is taken from
// io_selector on the first beat of a packet and held until the beat carrying
// io_in_last. Each channel has a one-entry registered slot and a counter of
// completed packets.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : selector, input stream, four output streams, counters
// Parameters:
//   WIDTH : payload bits per beat (must equal stream_demux4_pkg::DATA_W)
//   CNT_W : width of each per-channel packet counter
// -----------------------------------------------------------------------------
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 8
) (
  input  logic          clock,
  input  logic          reset,
  stream_demux4_if.slave bus
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  route_q, route_d, route_eff;
  logic [NUM_CH-1:0] slot_free, slot_load, slot_valid, slot_last;
  beat_t             slot_beat [NUM_CH];
  logic [CNT_W-1:0]  slot_count [NUM_CH];
  beat_t             in_beat;
  logic              accept;

  // Mid-packet the locked route is used, so selector changes are ignored.
  assign route_eff      = (state_q == IDLE) ? bus.io_selector : route_q;
  assign bus.io_in_ready = slot_free[route_eff];
  assign accept          = bus.io_in_valid && bus.io_in_ready;

  assign in_beat.data = DATA_W'(bus.io_in_data);
  assign in_beat.last = bus.io_in_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // A single-beat packet accepted in IDLE never opens a packet.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      IDLE: begin
        if (accept && !bus.io_in_last) begin
          state_d = BUSY;
          route_d = bus.io_selector;
        end
      end
      BUSY: begin
        if (accept && bus.io_in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    assign slot_load[gi] = accept && (route_eff == SEL_W'(gi));

    demux_slot #(
      .CNT_W (CNT_W)
    ) u_slot (
      .clock     (clock),
      .reset     (reset),
      .load      (slot_load[gi]),
      .load_beat (in_beat),
      .out_ready (bus.io_out_ready[gi]),
      .out_valid (slot_valid[gi]),
      .out_beat  (slot_beat[gi]),
      .free      (slot_free[gi]),
      .count     (slot_count[gi])
    );

    assign slot_last[gi]       = slot_beat[gi].last;
    assign bus.io_out_data[gi] = WIDTH'(slot_beat[gi].data);
    assign bus.io_count[gi]    = slot_count[gi];
  end

  assign bus.io_out_valid = slot_valid;
  assign bus.io_out_last  = slot_last;

endmodule

// File: tb/tb_stream_demux4.sv
// -----------------------------------------------------------------------------
// tb_stream_demux4
// Self-checking bench for stream_demux4: a table of directed cycles, a few
// hand-written multi-cycle sequences and a randomized phase, all checked
// against a pending-beat scoreboard of each channel.
// -----------------------------------------------------------------------------
module tb_stream_demux4;
  import stream_demux4_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  stream_demux4_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  stream_demux4 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: at most one accepted-but-undelivered beat per channel,
  // packet-open flag with its locked channel, delivered-packet totals.
  bit         m_pend [NUM_CH];
  logic [W-1:0] m_data [NUM_CH];
  bit         m_last [NUM_CH];
  int         m_cnt  [NUM_CH];
  bit         m_open;
  int         m_lock;

  typedef struct {
    logic [1:0]  sel;
    logic        vld;
    logic [7:0]  data;
    logic        last;
    logic [3:0]  ready;
    logic [3:0]  exp_valid;
    int          exp_ch;
    logic [7:0]  exp_data;
    logic        exp_last;
    logic [31:0] exp_counts;
  } vec_t;

  vec_t vecs [11];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_pend[ch] = 1'b0;
      m_data[ch] = '0;
      m_last[ch] = 1'b0;
      m_cnt[ch]  = 0;
    end
    m_open = 1'b0;
    m_lock = 0;
  endtask

  // Drives one cycle from a negedge, checks the pre-edge view against the
  // model, advances the model across the edge and returns at the next negedge.
  task automatic apply_stimulus(input logic [1:0] sel, input logic vld,
                                input logic [7:0] data, input logic last,
                                input logic [3:0] ready);
    int route;
    bit exp_rdy;
    bit acc;
    bus.io_selector  = sel;
    bus.io_in_valid  = vld;
    bus.io_in_data   = data;
    bus.io_in_last   = last;
    bus.io_out_ready = ready;
    #1;
    route   = m_open ? m_lock : int'(sel);
    exp_rdy = !m_pend[route] || ready[route];
    check_output("in_ready", 32'(bus.io_in_ready), 32'(exp_rdy));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check_output($sformatf("out%0d_valid", ch), 32'(bus.io_out_valid[ch]),
                   32'(m_pend[ch]));
      if (m_pend[ch]) begin
        check_output($sformatf("out%0d_data", ch), 32'(bus.io_out_data[ch]),
                     32'(m_data[ch]));
        check_output($sformatf("out%0d_last", ch), 32'(bus.io_out_last[ch]),
                     32'(m_last[ch]));
      end
      check_output($sformatf("count%0d", ch), 32'(bus.io_count[ch]),
                   32'(m_cnt[ch] % 256));
    end
    acc = vld && exp_rdy;
    @(posedge clock);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m_pend[ch] && ready[ch]) begin
        if (m_last[ch]) m_cnt[ch]++;
        m_pend[ch] = 1'b0;
      end
    end
    if (acc) begin
      m_pend[route] = 1'b1;
      m_data[route] = data;
      m_last[route] = last;
      if (!m_open && !last) begin
        m_open = 1'b1;
        m_lock = int'(sel);
      end else if (m_open && last) begin
        m_open = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    bus.io_in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int c0;
    bus.io_selector  = '0;
    bus.io_in_valid  = 1'b0;
    bus.io_in_data   = '0;
    bus.io_in_last   = 1'b0;
    bus.io_out_ready = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check_output("rst_valid", 32'(bus.io_out_valid), 32'h0);
    check_output("rst_counts", 32'(bus.io_count), 32'h0);
    check_output("rst_in_ready", 32'(bus.io_in_ready), 32'h1);

    // Single-beat routing, packet lock, then a fresh packet proving IDLE.
    vecs[0]  = '{2'd0, 1'b1, 8'hA0, 1'b1, 4'hF, 4'b0001,  0, 8'hA0, 1'b1, 32'h00000000};
    vecs[1]  = '{2'd1, 1'b1, 8'hA1, 1'b1, 4'hF, 4'b0010,  1, 8'hA1, 1'b1, 32'h00000001};
    vecs[2]  = '{2'd2, 1'b1, 8'hA2, 1'b1, 4'hF, 4'b0100,  2, 8'hA2, 1'b1, 32'h00000101};
    vecs[3]  = '{2'd3, 1'b1, 8'hA3, 1'b1, 4'hF, 4'b1000,  3, 8'hA3, 1'b1, 32'h00010101};
    vecs[4]  = '{2'd0, 1'b0, 8'h00, 1'b0, 4'hF, 4'b0000, -1, 8'h00, 1'b0, 32'h01010101};
    vecs[5]  = '{2'd2, 1'b1, 8'hB0, 1'b0, 4'hF, 4'b0100,  2, 8'hB0, 1'b0, 32'h01010101};
    vecs[6]  = '{2'd1, 1'b1, 8'hB1, 1'b0, 4'hF, 4'b0100,  2, 8'hB1, 1'b0, 32'h01010101};
    vecs[7]  = '{2'd1, 1'b1, 8'hB2, 1'b1, 4'hF, 4'b0100,  2, 8'hB2, 1'b1, 32'h01010101};
    vecs[8]  = '{2'd1, 1'b0, 8'h00, 1'b0, 4'hF, 4'b0000, -1, 8'h00, 1'b0, 32'h01020101};
    vecs[9]  = '{2'd1, 1'b1, 8'hC0, 1'b1, 4'hF, 4'b0010,  1, 8'hC0, 1'b1, 32'h01020101};
    vecs[10] = '{2'd0, 1'b0, 8'h00, 1'b0, 4'hF, 4'b0000, -1, 8'h00, 1'b0, 32'h01020201};

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].last, vecs[i].ready);
      check_output($sformatf("vec%0d_valid", i), 32'(bus.io_out_valid), 32'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d_counts", i), 32'(bus.io_count), vecs[i].exp_counts);
      if (vecs[i].exp_ch >= 0) begin
        check_output($sformatf("vec%0d_data", i), 32'(bus.io_out_data[vecs[i].exp_ch]),
                     32'(vecs[i].exp_data));
        check_output($sformatf("vec%0d_last", i), 32'(bus.io_out_last[vecs[i].exp_ch]),
                     32'(vecs[i].exp_last));
      end
    end

    // Backpressure isolation: ch1 stalled, ch3 keeps flowing.
    apply_stimulus(2'd1, 1'b1, 8'hD0, 1'b1, 4'b1101);
    apply_stimulus(2'd1, 1'b1, 8'hD1, 1'b1, 4'b1101);
    check_output("bp_hold_valid", 32'(bus.io_out_valid[1]), 32'h1);
    check_output("bp_hold_data", 32'(bus.io_out_data[1]), 32'hD0);
    apply_stimulus(2'd3, 1'b1, 8'hE0, 1'b1, 4'b1101);
    check_output("bp_other_valid", 32'(bus.io_out_valid[3]), 32'h1);
    check_output("bp_other_data", 32'(bus.io_out_data[3]), 32'hE0);
    check_output("bp_still_held", 32'(bus.io_out_data[1]), 32'hD0);
    apply_stimulus(2'd1, 1'b1, 8'hD1, 1'b1, 4'b1111);
    check_output("bp_release_data", 32'(bus.io_out_data[1]), 32'hD1);
    apply_stimulus(2'd0, 1'b0, 8'h00, 1'b0, 4'b1111);

    // Full-throughput 16-beat packet to ch0.
    c0 = m_cnt[0];
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(2'd0, 1'b1, 8'(8'h10 + i), (i == 15), 4'hF);
      check_output("tp_valid", 32'(bus.io_out_valid[0]), 32'h1);
      check_output("tp_data", 32'(bus.io_out_data[0]), 32'(8'h10 + i));
    end
    apply_stimulus(2'd0, 1'b0, 8'h00, 1'b0, 4'hF);
    check_output("tp_count", 32'(bus.io_count[0]), 32'((c0 + 1) % 256));

    // Reset in the middle of a 4-beat packet to ch2.
    apply_stimulus(2'd2, 1'b1, 8'hF0, 1'b0, 4'hF);
    apply_stimulus(2'd1, 1'b1, 8'hF1, 1'b0, 4'hF);
    do_reset();
    check_output("mid_rst_valid", 32'(bus.io_out_valid), 32'h0);
    check_output("mid_rst_counts", 32'(bus.io_count), 32'h0);
    apply_stimulus(2'd0, 1'b1, 8'hF2, 1'b1, 4'hF);
    check_output("post_rst_valid", 32'(bus.io_out_valid), 32'b0001);
    check_output("post_rst_data", 32'(bus.io_out_data[0]), 32'hF2);
    apply_stimulus(2'd0, 1'b0, 8'h00, 1'b0, 4'hF);

    // Counter wrap on ch3: 256 single-beat packets.
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(2'd3, 1'b1, 8'(i), 1'b1, 4'hF);
      if (i == 255) check_output("wrap_255", 32'(bus.io_count[3]), 32'd255);
    end
    apply_stimulus(2'd0, 1'b0, 8'h00, 1'b0, 4'hF);
    check_output("wrap_0", 32'(bus.io_count[3]), 32'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     8'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'd0, 1'b0, 8'h00, 1'b0, 4'hF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
Name: stream_demux4

Overview:
- Packet-aware 1-to-4 stream demultiplexer with valid/ready handshake; the distribution-side counterpart of the 4:1 selector path in the combinational-circuit library.
- Routes each packet from one input stream to one of four output streams.
- The route is chosen by io_selector on the first beat of a packet and held until the beat with io_in_last.
- Each output has a one-entry registered slot; the block also keeps a per-output completed-packet counter.

Parameters:
- WIDTH, 8, data bits per beat.
- CNT_W, 8, width of each per-output packet counter.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- io_selector  input  2  destination channel; sampled only on the first beat of a packet.
- io_in_valid  input  1  input beat valid.
- io_in_ready  output  1  input beat accepted when valid and ready are both high.
- io_in_data  input  WIDTH  input beat payload.
- io_in_last  input  1  marks the final beat of a packet.
- io_out_N_valid  output  1  (N = 0..3) channel N slot holds a beat.
- io_out_N_ready  input  1  channel N consumer ready.
- io_out_N_data  output  WIDTH  channel N payload.
- io_out_N_last  output  1  channel N last flag.
- io_count_N  output  CNT_W  packets fully delivered on channel N.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, route_q=0, all slot valid/data/last=0, all io_count_N=0. Applies mid-packet: in-flight slots are discarded and any partial packet is abandoned.
- FSM states: IDLE (no packet open) and BUSY (packet open).
- Effective route: route_eff = io_selector in IDLE, route_q in BUSY. io_selector changes while BUSY are ignored.
- Slot free: slot_free[N] = !valid[N] || io_out_N_ready[N], giving pass-through ready and full throughput.
- io_in_ready = slot_free[route_eff]. It is combinational from io_selector/route_q and io_out_N_ready only, never from io_in_valid.
- Accept: accept = io_in_valid && io_in_ready.
- IDLE transitions:
  - accept && !last: route_q <= io_selector; go to BUSY.
  - accept && last: single-beat packet; stay IDLE.
- BUSY transitions:
  - accept && last: go to IDLE.
  - Otherwise stay BUSY.
- Slot N update, highest priority first:
  - accept and route_eff==N: load data/last, valid<=1. This also covers a same-cycle drain and refill, where valid stays 1.
  - Else io_out_N_valid && io_out_N_ready: valid<=0.
  - Else hold.
- Latency: beat accepted in cycle t appears on its output in cycle t+1.
- Output stability: while io_out_N_valid && !io_out_N_ready, data/last are held stable.
- Slots drain independently; a stalled channel never blocks beats routed to another channel.
- A packet may start on a new channel while older beats of a previous packet still sit in another channel's slot.
- Counters: io_count_N increments by 1 on an output handshake with io_out_N_last=1, modulo 2^CNT_W (255 -> 0 wraps silently).
- No data transformation. Beats are never dropped or duplicated except by reset.

Decomposition:
- Shared package:
  - NUM_CH=4 and SEL_W=2 constants.
  - FSM enum {IDLE, BUSY}.
  - Beat bundle {data[WIDTH], last}.
- Sub-module demux_slot: one-entry registered holding stage.
  - Ports: load, load_beat, out_ready, out_valid, out_beat, free.
  - Contains the per-channel packet counter.
  - Instantiated 4 times, mirroring the Mux2-composition style.
- Top level holds the FSM, route_q, route_eff select and the io_in_ready mux.

Test Plan:
- Single-beat routing: all io_out_N_ready=1; send beats 0xA0..0xA3 with last=1 and selector 0,1,2,3 on consecutive cycles -> each beat appears on out_0..out_3 one cycle later; io_count_0..3 each read 1; io_in_ready constant 1.
- Packet lock: 3-beat packet, selector=2 on beat 0, then selector driven to 1 on beats 1-2 -> all three beats on out_2 with last only on the third; state returns to IDLE; io_count_2=1, io_count_1=0.
- Backpressure isolation: io_out_1_ready=0; send beat to ch1, then a second beat to ch1 -> io_in_ready=0 and out_1_data holds the first beat. Meanwhile beats to ch3 are accepted and delivered. Raise io_out_1_ready -> second beat is delivered the next cycle, with no loss.
- Full throughput with same-cycle drain/refill: continuous 16-beat packet to ch0 with ready=1 -> one beat per cycle, out_0_valid never drops mid-stream, io_count_0 increments once.
- Counter wrap: deliver 256 single-beat packets to ch3 -> io_count_3 goes 255 -> 0.
- Reset mid-packet: assert reset after beat 1 of a 4-beat packet to ch2 -> the next cycle shows all valids 0, counters 0, state IDLE; a following packet with selector=0 routes to ch0.
